// File: rtl/rotate_decoder_pkg.sv
// Shared types and helpers for the rotate decoder: FSM states and minimal-form conversion.
package rotate_decoder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic        dir;
        logic [15:0] amt;
    } min_form_t;

    // Half-way rotation ties go to the left so the ALU never sees dir=1 for k==width/2.
    function automatic min_form_t to_minimal(input int unsigned k, input int unsigned width);
        min_form_t m;
        if (k <= width / 2) begin
            m.dir = 1'b0;
            m.amt = 16'(k);
        end else begin
            m.dir = 1'b1;
            m.amt = 16'(width - k);
        end
        return m;
    endfunction

endpackage

// File: rtl/rotate_decoder_rotl1.sv
// Purpose: combinational 1-bit left rotate of a WIDTH-bit word.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
module rotl1 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = {x[WIDTH-2:0], x[WIDTH-1]};

endmodule

// File: rtl/rotate_decoder.sv
// Purpose: find smallest k with rotl(A,k)==Y; report k raw and as minimal dir/amt.
// Latency: done pulses k+1 cycles after start on a match, WIDTH cycles with no match.
// Backpressure: start ignored while busy; no queuing, caller retries after done.
module rotate_decoder
    import rotate_decoder_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [AMT_W-1:0] amt_left,
    output logic             dir,
    output logic [AMT_W-1:0] amt
);

    localparam logic [AMT_W-1:0] K_LAST = AMT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] rot;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] rot_next;
    logic [AMT_W-1:0] k;
    min_form_t        k_min;

    rotl1 #(.WIDTH(WIDTH)) u_rotl1 (
        .x (rot),
        .y (rot_next)
    );

    assign k_min = to_minimal(int'(k), WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rot      <= '0;
            target   <= '0;
            k        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            found    <= 1'b0;
            amt_left <= '0;
            dir      <= 1'b0;
            amt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rot    <= A;
                        target <= Y;
                        k      <= '0;
                        busy   <= 1'b1;
                        state  <= SEARCH;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEARCH: begin
                    // Checking k before advancing makes the first hit the smallest k.
                    if (rot == target) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        found    <= 1'b1;
                        amt_left <= k;
                        dir      <= k_min.dir;
                        amt      <= AMT_W'(k_min.amt);
                    end else if (k == K_LAST) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        found    <= 1'b0;
                        amt_left <= '0;
                        dir      <= 1'b0;
                        amt      <= '0;
                    end else begin
                        rot <= rot_next;
                        k   <= k + AMT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_decoder.sv
// Directed table-driven bench for rotate_decoder (WIDTH=8) plus control-disturbance sequences.
module tb_rotate_decoder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] Y;
    logic       busy;
    logic       done;
    logic       found;
    logic [2:0] amt_left;
    logic       dir;
    logic [2:0] amt;

    int checks;
    int failures;

    rotate_decoder #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (A),
        .Y        (Y),
        .busy     (busy),
        .done     (done),
        .found    (found),
        .amt_left (amt_left),
        .dir      (dir),
        .amt      (amt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] y;
        logic       exp_found;
        int         exp_amt_left;
        logic       exp_dir;
        int         exp_amt;
        int         exp_lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input vec_t v);
        chk({tag, ".found"}, int'(found), int'(v.exp_found));
        chk({tag, ".amt_left"}, int'(amt_left), v.exp_amt_left);
        chk({tag, ".dir"}, int'(dir), int'(v.exp_dir));
        chk({tag, ".amt"}, int'(amt), v.exp_amt);
    endtask

    // Issue a start at the next edge; returns after that edge (+1) with start dropped.
    task automatic issue(input logic [7:0] a, input logic [7:0] y);
        @(negedge clk);
        A = a;
        Y = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = ~a;
        Y = ~y;
    endtask

    // Counts edges until done is seen; busy counted from the sample just after the start edge.
    task automatic wait_done(output int lat, output int bcnt, output bit timed_out);
        lat = 0;
        bcnt = busy ? 1 : 0;
        timed_out = 1'b0;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (busy) bcnt++;
            if (lat >= 20) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  lat;
        int  bcnt;
        bit  to;
        vec_t v;

        checks = 0;
        failures = 0;

        //           a      y      found amt_left dir amt lat
        vecs[0]  = '{8'h81, 8'h81, 1'b1, 0, 1'b0, 0, 1};
        vecs[1]  = '{8'h01, 8'h08, 1'b1, 3, 1'b0, 3, 4};
        vecs[2]  = '{8'h01, 8'h10, 1'b1, 4, 1'b0, 4, 5};
        vecs[3]  = '{8'h01, 8'h80, 1'b1, 7, 1'b1, 1, 8};
        vecs[4]  = '{8'h0F, 8'h87, 1'b1, 7, 1'b1, 1, 8};
        vecs[5]  = '{8'h03, 8'h05, 1'b0, 0, 1'b0, 0, 8};
        vecs[6]  = '{8'h00, 8'h00, 1'b1, 0, 1'b0, 0, 1};
        vecs[7]  = '{8'hFF, 8'hFF, 1'b1, 0, 1'b0, 0, 1};
        vecs[8]  = '{8'h55, 8'hAA, 1'b1, 1, 1'b0, 1, 2};
        vecs[9]  = '{8'h80, 8'h01, 1'b1, 1, 1'b0, 1, 2};
        vecs[10] = '{8'hC0, 8'h03, 1'b1, 2, 1'b0, 2, 3};
        vecs[11] = '{8'h01, 8'h20, 1'b1, 5, 1'b1, 3, 6};
        vecs[12] = '{8'h12, 8'h21, 1'b1, 4, 1'b0, 4, 5};

        rst_n = 1'b0;
        start = 1'b0;
        A = 8'h00;
        Y = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.found", int'(found), 0);
        chk("reset.amt_left", int'(amt_left), 0);
        chk("reset.dir", int'(dir), 0);
        chk("reset.amt", int'(amt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            issue(v.a, v.y);
            wait_done(lat, bcnt, to);
            chk($sformatf("v%0d.timeout", i), int'(to), 0);
            chk($sformatf("v%0d.latency", i), lat, v.exp_lat);
            chk($sformatf("v%0d.busy_cycles", i), bcnt, v.exp_lat);
            chk($sformatf("v%0d.busy_in_done", i), int'(busy), 0);
            check_result($sformatf("v%0d", i), v);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.done_one_cycle", i), int'(done), 0);
            check_result($sformatf("v%0d.hold", i), v);
        end

        // Back-to-back: new start accepted during the DONE cycle.
        issue(8'h55, 8'hAA);
        wait_done(lat, bcnt, to);
        chk("b2b.first_latency", lat, 2);
        check_result("b2b.first", vecs[8]);
        A = 8'h12;
        Y = 8'h21;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b.busy_restart", int'(busy), 1);
        chk("b2b.done_low", int'(done), 0);
        wait_done(lat, bcnt, to);
        chk("b2b.second_latency", lat, 5);
        check_result("b2b.second", vecs[12]);

        // Start pulsed mid-search must not disturb the running request.
        issue(8'h01, 8'h80);
        @(posedge clk);
        #1;
        A = 8'h01;
        Y = 8'h02;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 2;
        bcnt = 0;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            if (done || lat >= 20) break;
        end
        chk("ignore.latency", lat, 8);
        check_result("ignore", vecs[3]);

        // Async reset mid-search: outputs clear at once, no done pulse afterwards.
        issue(8'h01, 8'h80);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.done", int'(done), 0);
        chk("midrst.found", int'(found), 0);
        chk("midrst.amt_left", int'(amt_left), 0);
        chk("midrst.dir", int'(dir), 0);
        chk("midrst.amt", int'(amt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bcnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) bcnt++;
        end
        chk("midrst.no_activity", bcnt, 0);

        issue(8'h01, 8'h08);
        wait_done(lat, bcnt, to);
        chk("after_rst.latency", lat, 4);
        check_result("after_rst", vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rotate_decoder.md
Name: rotate_decoder

Overview:
- Inverse of the ALU's 1-bit rotate unit.
- Given an original byte A and a candidate rotated byte Y, it searches sequentially for the left-rotate count k such that rotl(A,k) == Y.
- It reports k both raw and in minimal direction/amount form, matching the ALU's dir convention: 0 = left, 1 = right.
- Sits beside the ALU shifter. Used by the ALU self-check and by the verification harness to recover rotate history.

Parameters:
- WIDTH, 8, operand width in bits; must be even and at least 2.
- AMT_W, $clog2(WIDTH), width of the amount fields; derived, not overridden.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- A  input  WIDTH  original operand; latched on an accepted start.
- Y  input  WIDTH  rotated target; latched on an accepted start.
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse when a result is valid.
- found  output  1  a match exists for some k in 0..WIDTH-1.
- amt_left  output  AMT_W  smallest matching left-rotate count k.
- dir  output  1  minimal-form direction; 0 = left, 1 = right.
- amt  output  AMT_W  minimal-form count: k if k <= WIDTH/2, else WIDTH-k.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rot/target/k cleared. busy, done, found, amt_left, dir, amt all 0.
- Reset mid-search aborts with no done pulse.
- States: IDLE, SEARCH, DONE.
- IDLE or DONE with start=1: rot<=A, target<=Y, k<=0, state<=SEARCH, busy<=1.
- Start while in SEARCH is ignored; no queuing.
- SEARCH, each cycle with current k:
  - If rot==target: state<=DONE, found<=1, amt_left<=k, dir/amt loaded from k.
  - Else if k==WIDTH-1: state<=DONE, found<=0, amt_left/dir/amt<=0.
  - Else: rot<=rotl(rot,1), k<=k+1.
- Latency: start sampled at edge E0; done is visible after edge E(k+1) on a match, after E(WIDTH) with no match. For WIDTH=8 that is 1..8 cycles.
- DONE lasts exactly one cycle with done=1, busy=0.
- DONE next state: SEARCH if start=1 that cycle (back-to-back), else IDLE.
- All outputs are registered. found/amt_left/dir/amt update only when entering DONE and hold until the next DONE.
- Multiple matches (periodic patterns): the smallest k wins.
  - A=0x00/Y=0x00 gives k=0.
  - A=0xFF/Y=0xFF gives k=0.
- Minimal form:
  - k==0 gives dir=0, amt=0.
  - k==WIDTH/2 is a tie and resolves to dir=0, amt=WIDTH/2.
  - k>WIDTH/2 gives dir=1, amt=WIDTH-k.
- A and Y changing after an accepted start has no effect on the search in progress.

Decomposition:
- Package rotate_decoder_pkg:
  - state enum {IDLE, SEARCH, DONE}.
  - localparam DEFAULT_WIDTH=8.
  - function to_minimal(k) returning {dir, amt}.
- Sub-module rotl1 (WIDTH parameterised): combinational 1-bit left rotate, {X[WIDTH-2:0], X[WIDTH-1]}.
- The top level contains the FSM, the k counter, the rot/target registers and the result registers.

Test Plan:
- A=0x81, Y=0x81, start -> done 1 cycle after start; found=1, amt_left=0, dir=0, amt=0.
- A=0x01, Y=0x08 -> done 4 cycles after start; found=1, amt_left=3, dir=0, amt=3. A=0x01, Y=0x10 -> amt_left=4, dir=0, amt=4 (tie case).
- A=0x01, Y=0x80 -> done 8 cycles after start; found=1, amt_left=7, dir=1, amt=1. A=0x0F, Y=0x87 -> amt_left=7, dir=1, amt=1.
- A=0x03, Y=0x05 -> done 8 cycles after start; found=0, amt_left=0, dir=0, amt=0; busy high for exactly 8 cycles.
- A=0x55, Y=0xAA -> amt_left=1 (smallest of 1,3,5,7), dir=0, amt=1. Then issue start in the DONE cycle with A=0x12, Y=0x21 -> second done with amt_left=4, dir=0, amt=4.
- Control disturbances:
  - start pulsed during SEARCH -> ignored; result matches the first request.
  - rst_n low mid-SEARCH -> all outputs 0 immediately, no done pulse.
  - After release, a new start works normally.
